// File: rtl/ascon_perm_arbiter.sv
// Round-robin scheduler sharing one Ascon permutation core between two requesters.
// Define ASCON_ARB_TIMEOUT_EN to add a watchdog that aborts jobs whose core never finishes.
module ascon_perm_arbiter #(
  parameter logic [5:0]  TIMEOUT    = 6'd63,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [319:0] req0_state,
  input  logic [3:0]   req0_rounds,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [319:0] rsp0_state,
  output logic         rsp0_err,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [319:0] req1_state,
  input  logic [3:0]   req1_rounds,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [319:0] rsp1_state,
  output logic         rsp1_err,
  output logic         core_start,
  output logic [4:0]   core_rounds,
  output logic [319:0] core_state,
  input  logic [319:0] core_out,
  input  logic         core_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic         ptr;
  logic         own;
  logic         err;
  logic [319:0] job_state;
  logic [3:0]   job_rounds;
  logic [319:0] result;

  logic         grant;
  logic         acc;
  logic         bad;
  logic         rsp_hs;
  logic [319:0] acc_state;
  logic [3:0]   acc_rounds;
  logic         wd_hit;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant      = req1_valid & (~req0_valid | ptr);
    acc_state  = grant ? req1_state : req0_state;
    acc_rounds = grant ? req1_rounds : req0_rounds;
    bad        = (acc_rounds == 4'd0) ||
                 ({28'd0, acc_rounds} > MAX_ROUNDS);
    acc        = req0_ready | req1_ready;
    rsp_hs     = (state == RESP) &&
                 (own ? rsp1_ready : rsp0_ready);
  end

`ifdef ASCON_ARB_TIMEOUT_EN
  logic [5:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt <= 6'd0;
    end else if (state == LAUNCH) begin
      wd_cnt <= 6'd0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 6'd1;
    end
  end

  assign wd_hit = (state == WAIT) &&
                  (wd_cnt == TIMEOUT - 6'd1);
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT;
  assign wd_hit     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc) begin
          state_nx = bad ? RESP : LAUNCH;
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        if (core_done || wd_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = resetn && (state == IDLE) &&
                  req0_valid && !grant;
    req1_ready  = resetn && (state == IDLE) &&
                  req1_valid && grant;
    core_start  = (state == LAUNCH);
    busy        = (state != IDLE);
    rsp0_valid  = (state == RESP) && !own;
    rsp1_valid  = (state == RESP) && own;
    rsp0_err    = rsp0_valid & err;
    rsp1_err    = rsp1_valid & err;
    rsp0_state  = result;
    rsp1_state  = result;
    core_state  = job_state;
    core_rounds = {1'b0, job_rounds};
  end

  // Result starts as the input so rejects and timeouts echo it back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr        <= 1'b0;
      own        <= 1'b0;
      err        <= 1'b0;
      job_state  <= '0;
      job_rounds <= 4'd0;
      result     <= '0;
    end else begin
      if (acc) begin
        ptr        <= ~grant;
        own        <= grant;
        err        <= bad;
        job_state  <= acc_state;
        job_rounds <= acc_rounds;
        result     <= acc_state;
      end
      if ((state == WAIT) && core_done) begin
        result <= core_out;
        err    <= 1'b0;
      end else if (wd_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Directed bench for ascon_perm_arbiter with a transaction-level model and core stub.
// Watchdog checks are built only when ASCON_ARB_TIMEOUT_EN is defined.
module tb_ascon_perm_arbiter;

  localparam logic [5:0] TO = 6'd63;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req0_valid = 1'b0, req0_ready;
  logic [319:0] req0_state = '0;
  logic [3:0]   req0_rounds = 4'd0;
  logic         rsp0_valid, rsp0_ready = 1'b1, rsp0_err;
  logic [319:0] rsp0_state;
  logic         req1_valid = 1'b0, req1_ready;
  logic [319:0] req1_state = '0;
  logic [3:0]   req1_rounds = 4'd0;
  logic         rsp1_valid, rsp1_ready = 1'b1, rsp1_err;
  logic [319:0] rsp1_state;
  logic         core_start, core_done, busy;
  logic [4:0]   core_rounds;
  logic [319:0] core_state, core_out;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;

  ascon_perm_arbiter #(.TIMEOUT(TO), .MAX_ROUNDS(12)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_rounds(req0_rounds),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_state(rsp0_state), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_rounds(req1_rounds),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_state(rsp1_state), .rsp1_err(rsp1_err),
    .core_start(core_start), .core_rounds(core_rounds),
    .core_state(core_state), .core_out(core_out),
    .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [319:0] perm(input logic [319:0] s,
                                        input logic [4:0] r);
    return {s[318:0], s[319]} ^ {64{r}};
  endfunction

  task automatic chk(input string nm, input logic [319:0] act,
                     input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Core stub: done pulses core_lat cycles after start; negative never finishes.
  int           core_lat = 12;
  int           rem = -1;
  bit           inject = 1'b0;
  logic [319:0] cap_s;
  logic [4:0]   cap_r;

  initial begin
    bit rs;
    core_done = 1'b0;
    core_out  = '0;
    forever begin
      @(posedge clk);
      rs = !resetn;
      #1;
      core_done = 1'b0;
      if (rs) begin
        rem = -1;
      end else if (core_start) begin
        cap_s = core_state;
        cap_r = core_rounds;
        rem   = core_lat;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          core_done = 1'b1;
          core_out  = perm(cap_s, cap_r);
          rem       = -1;
        end
      end
      if (inject) core_done = 1'b1;
    end
  end

  // Transaction model: one job in flight, responses due after done or reject.
  bit           fl = 1'b0, f_own, f_legal, f_err, ptr_m = 1'b0;
  bit           post_rst = 1'b0, g, e0, e1, v;
  int           acc_c, due_c;
  logic [319:0] f_in, f_res;
  logic [3:0]   f_rnd;

  always @(negedge clk) begin
    if (core_start) n_start++;
    if (!resetn) begin
      fl       = 1'b0;
      ptr_m    = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        post_rst = 1'b0;
        chk("rst_core_state", core_state, '0);
        chk("rst_core_rounds", core_rounds, 0);
        chk("rst_rsp0_state", rsp0_state, '0);
        chk("rst_rsp1_state", rsp1_state, '0);
        chk("rst_rsp_err", {rsp0_err, rsp1_err}, 0);
      end
      chk("ready_excl", req0_ready & req1_ready, 0);
      chk("busy", busy, fl);
      if (fl) begin
        e0 = 1'b0;
        e1 = 1'b0;
      end else begin
        g  = (req0_valid && req1_valid) ? ptr_m : req1_valid;
        e0 = req0_valid && !g;
        e1 = req1_valid && g;
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("core_start", core_start, fl && f_legal && cyc == acc_c + 1);
      if (fl && f_legal && due_c < 0 && cyc > acc_c) begin
        chk("core_state", core_state, f_in);
        chk("core_rounds", core_rounds, {1'b0, f_rnd});
        if (cyc > acc_c + 1) begin
          if (core_done) due_c = cyc + 1;
`ifdef ASCON_ARB_TIMEOUT_EN
          else if (cyc - acc_c - 1 == int'(TO)) begin
            due_c = cyc + 1;
            f_res = f_in;
            f_err = 1'b1;
          end
`endif
        end
      end
      v = fl && due_c >= 0 && cyc >= due_c;
      chk("rsp0_valid", rsp0_valid, v && !f_own);
      chk("rsp1_valid", rsp1_valid, v && f_own);
      if (v) begin
        chk("rsp_state", f_own ? rsp1_state : rsp0_state, f_res);
        chk("rsp_err", f_own ? rsp1_err : rsp0_err, f_err);
      end
      if (v && (f_own ? rsp1_ready : rsp0_ready)) begin
        fl = 1'b0;
      end else if (!fl && ((req0_valid && req0_ready) ||
                           (req1_valid && req1_ready))) begin
        fl      = 1'b1;
        acc_c   = cyc;
        f_own   = req1_valid && req1_ready;
        f_in    = f_own ? req1_state : req0_state;
        f_rnd   = f_own ? req1_rounds : req0_rounds;
        f_legal = f_rnd != 4'd0 && f_rnd <= 4'd12;
        f_err   = !f_legal;
        f_res   = f_legal ? perm(f_in, {1'b0, f_rnd}) : f_in;
        due_c   = f_legal ? -1 : cyc + 1;
        ptr_m   = !f_own;
      end
    end
  end

  task automatic wait_acc(input int r, output int ac);
    bit ok = 1'b0;
    ac = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (r == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
        ok = 1'b1;
        ac = cyc;
      end
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL accept_timeout req%0d: got none want accept", r);
    end
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic send(input int r, input logic [319:0] s,
                      input logic [3:0] n, output int ac);
    @(posedge clk);
    #1;
    if (r == 0) begin
      req0_valid = 1'b1; req0_state = s; req0_rounds = n;
    end else begin
      req1_valid = 1'b1; req1_state = s; req1_rounds = n;
    end
    wait_acc(r, ac);
  endtask

  task automatic get(input int r, output logic [319:0] s,
                     output logic e, output int c);
    bit ok = 1'b0;
    c = -1;
    s = '0;
    e = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (r == 0 ? rsp0_valid : rsp1_valid) begin
        ok = 1'b1;
        c  = cyc;
        s  = r == 0 ? rsp0_state : rsp1_state;
        e  = r == 0 ? rsp0_err : rsp1_err;
      end
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL rsp_timeout rsp%0d: got none want response", r);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL drain_timeout: got busy want idle");
    end
  endtask

  initial begin
    int           ac, c, who, s0;
    logic [319:0] s;
    logic         e;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Single job, all-zero state, 12 rounds.
    core_lat = 12;
    s0 = n_start;
    send(0, '0, 4'd12, ac);
    get(0, s, e, c);
    chk("t1_state", s, {16{20'h6318C}});
    chk("t1_err", e, 0);
    chk("t1_latency", c - ac, 14);
    chk("t1_starts", n_start - s0, 1);

    // Contention from reset: grants alternate 0,1,0,1.
    @(posedge clk);
    #1;
    resetn = 1'b0;
    core_lat = 5;
    req0_valid = 1'b1; req0_state = {10{32'h01234567}}; req0_rounds = 4'd6;
    req1_valid = 1'b1; req1_state = {10{32'h89abcdef}}; req1_rounds = 4'd8;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int i = 0; i < 100 && who < 0; i++) begin
        @(negedge clk);
        if (req0_valid && req0_ready) who = 0;
        else if (req1_valid && req1_ready) who = 1;
      end
      chk("t2_grant_order", who, k % 2);
      @(posedge clk);
      #1;
      if (who == 0) req0_state = req0_state ^ {5{64'h5a5a}};
      else req1_state = req1_state ^ {5{64'ha5a5}};
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Illegal round counts are echoed back with err, core untouched.
    s0 = n_start;
    send(1, {10{32'hdeadbeef}}, 4'd0, ac);
    get(1, s, e, c);
    chk("t3_zero_state", s, {10{32'hdeadbeef}});
    chk("t3_zero_err", e, 1);
    chk("t3_zero_latency", c - ac, 1);
    send(1, {10{32'hcafef00d}}, 4'd13, ac);
    get(1, s, e, c);
    chk("t3_13_state", s, {10{32'hcafef00d}});
    chk("t3_13_err", e, 1);
    chk("t3_13_latency", c - ac, 1);
    chk("t3_no_start", n_start - s0, 0);

    // Response backpressure with requester 1 waiting.
    rsp0_ready = 1'b0;
    core_lat = 4;
    send(0, {10{32'h13579bdf}}, 4'd7, ac);
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_state = {10{32'h2468ace0}}; req1_rounds = 4'd3;
    get(0, s, e, c);
    chk("t4_state", s, perm({10{32'h13579bdf}}, 5'd7));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_valid_hold", rsp0_valid, 1);
      chk("t4_state_hold", rsp0_state, s);
      chk("t4_req1_blocked", req1_ready, 0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    wait_acc(1, ac);
    get(1, s, e, c);
    chk("t4_r1_state", s, perm({10{32'h2468ace0}}, 5'd3));
    drain();

    // Reset while waiting on the core drops the job.
    core_lat = 10;
    send(0, {10{32'h0f0f1e1e}}, 4'd10, ac);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    core_lat = 3;
    send(0, {10{32'h77aa55cc}}, 4'd3, ac);
    get(0, s, e, c);
    chk("t5_after_state", s, perm({10{32'h77aa55cc}}, 5'd3));
    chk("t5_after_err", e, 0);

    // Stray done while idle.
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_stray_idle", {busy, rsp0_valid, rsp1_valid}, 0);
    end

`ifdef ASCON_ARB_TIMEOUT_EN
    core_lat = -1;
    send(0, {10{32'h31415926}}, 4'd12, ac);
    get(0, s, e, c);
    chk("t7_wd_err", e, 1);
    chk("t7_wd_state", s, {10{32'h31415926}});
    chk("t7_wd_latency", c - ac, 65);
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t7_late_done", {busy, rsp0_valid, rsp1_valid}, 0);
    end
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
